// File: rtl/rv32_pkg.sv
// Shared rv32 pipeline types and constants.
//   fetch_state_e        : instruction-fetch FSM states
//   PC_INC               : sequential PC step (no compressed instructions)
//   if_id_pipeline_reg_t : IF/ID pipeline register {pc, instr, valid}
//   align_pc()           : clears bits [1:0] of an address
package rv32_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_pipeline_reg_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage of the rv32 five-stage pipeline.
// Owns the PC, issues one imem request at a time over req/gnt/rvalid and
// loads fetched words into the IF/ID register. Honours stall/flush from the
// hazard unit and redirects from EX; responses made stale by a redirect are
// consumed and dropped.
//
// Ports:
//   clk_i, rst_ni        : clock, synchronous active-low reset
//   stall_i              : hold if_id_o
//   flush_i              : bubble if_id_o when not stalled
//   redirect_i           : taken branch/jump
//   redirect_pc_i        : redirect target (bits [1:0] ignored)
//   imem_req_o/addr_o    : fetch request and address (addr = pc_q)
//   imem_gnt_i           : request accepted this cycle
//   imem_rvalid_i/rdata_i: response valid and instruction word
//   if_id_o              : registered {pc, instr, valid} to id_stage
module if_stage
    import rv32_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic                redirect_i,
    input  logic [31:0]         redirect_pc_i,
    output logic                imem_req_o,
    output logic [31:0]         imem_addr_o,
    input  logic                imem_gnt_i,
    input  logic                imem_rvalid_i,
    input  logic [31:0]         imem_rdata_i,
    output if_id_pipeline_reg_t if_id_o
);

    fetch_state_e        state_q, state_d;
    logic [31:0]         pc_q, pc_d;
    logic [31:0]         req_pc_q, req_pc_d;
    logic [31:0]         buf_instr_q, buf_instr_d;
    logic                discard_q, discard_d;
    if_id_pipeline_reg_t if_id_q, if_id_d;

    logic                deliver;
    logic [31:0]         deliver_instr;
    logic [31:0]         target_pc;

    assign target_pc   = align_pc(redirect_pc_i);
    assign imem_addr_o = pc_q;
    assign if_id_o     = if_id_q;

    // Fetch FSM, PC and one-word buffer.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        buf_instr_d   = buf_instr_q;
        discard_d     = discard_q;
        deliver       = 1'b0;
        deliver_instr = buf_instr_q;
        imem_req_o    = 1'b0;

        unique case (state_q)
            S_REQ: begin
                // rvalid here can only be left over from before reset; ignore it.
                if (redirect_i) begin
                    pc_d = target_pc;
                end else begin
                    imem_req_o = 1'b1;
                    if (imem_gnt_i) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + PC_INC;
                        state_d  = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (redirect_i) begin
                    pc_d = target_pc;
                end
                if (imem_rvalid_i) begin
                    if (discard_q || redirect_i) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else if (!stall_i) begin
                        deliver       = 1'b1;
                        deliver_instr = imem_rdata_i;
                        state_d       = S_REQ;
                    end else begin
                        buf_instr_d = imem_rdata_i;
                        state_d     = S_HOLD;
                    end
                end else if (redirect_i) begin
                    // The in-flight response now belongs to the old path.
                    discard_d = 1'b1;
                end
            end

            S_HOLD: begin
                if (redirect_i) begin
                    pc_d    = target_pc;
                    state_d = S_REQ;
                end else if (!stall_i) begin
                    deliver       = 1'b1;
                    deliver_instr = buf_instr_q;
                    state_d       = S_REQ;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase

        if (!rst_ni) begin
            imem_req_o = 1'b0;
        end
    end

    // IF/ID register: stall holds, flush bubbles, else load or bubble.
    always_comb begin
        if_id_d = '0;
        if (stall_i) begin
            if_id_d = if_id_q;
        end else if (flush_i) begin
            if_id_d = '0;
        end else if (deliver) begin
            if_id_d.pc    = req_pc_q;
            if_id_d.instr = deliver_instr;
            if_id_d.valid = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_REQ;
            pc_q        <= BOOT_ADDR;
            req_pc_q    <= '0;
            buf_instr_q <= '0;
            discard_q   <= 1'b0;
            if_id_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            buf_instr_q <= buf_instr_d;
            discard_q   <= discard_d;
            if_id_q     <= if_id_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    import rv32_pkg::*;

    logic                clk = 1'b0;
    logic                rst_ni;
    logic                stall_i;
    logic                flush_i;
    logic                redirect_i;
    logic [31:0]         redirect_pc_i;
    logic                imem_req_o;
    logic [31:0]         imem_addr_o;
    logic                imem_gnt_i;
    logic                imem_rvalid_i;
    logic [31:0]         imem_rdata_i;
    if_id_pipeline_reg_t if_id_o;

    always #5 clk = ~clk;

    if_stage #(
        .BOOT_ADDR(32'h0000_0000)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .if_id_o      (if_id_o)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic        stall_last = 1'b0;

    // Memory image: each address holds a distinct word.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h5EED_0013;
    endfunction

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        exp_q.push_back({pc, word_at(pc)});
    endtask

    // One cycle: drive inputs just after the rising edge, return at the falling edge.
    task automatic cyc(input logic g, input logic rv, input logic [31:0] rd, input logic st,
                       input logic fl, input logic re, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        imem_gnt_i    = g;
        imem_rvalid_i = rv;
        imem_rdata_i  = rd;
        stall_i       = st;
        flush_i       = fl;
        redirect_i    = re;
        redirect_pc_i = rpc;
        @(negedge clk);
    endtask

    always @(posedge clk) stall_last <= stall_i;

    // Scoreboard: every freshly loaded valid IF/ID entry must match the queue head.
    always @(negedge clk) begin
        if (rst_ni === 1'b1 && if_id_o.valid === 1'b1 && stall_last === 1'b0) begin
            n_cmp++;
            assert (exp_q.size() != 0)
            else begin
                n_err++;
                $error("FAIL unexpected_delivery: observed pc %h, required no delivery",
                       if_id_o.pc);
            end
            if (exp_q.size() != 0) begin
                check("delivery", {1'b0, if_id_o.pc, if_id_o.instr}, {1'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst_ni        = 1'b0;
        stall_i       = 1'b0;
        flush_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;

        // Reset
        @(negedge clk);
        check("rst_req", 65'(imem_req_o), 65'd0);
        check("rst_ifid", 65'(if_id_o), 65'd0);
        check("rst_addr", 65'(imem_addr_o), 65'h0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(negedge clk);
        check("boot_req", 65'(imem_req_o), 65'd1);

        // Immediate gnt, rvalid one cycle later
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("t1_addr0", 65'(imem_addr_o), 65'h0);
        push(32'h0);
        cyc(0, 1, word_at(32'h0), 0, 0, 0, 0);
        check("t1_wait_req", 65'(imem_req_o), 65'd0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("t1_addr4", 65'({imem_req_o, imem_addr_o}), {32'd0, 1'b1, 32'h4});
        push(32'h4);
        cyc(0, 1, word_at(32'h4), 0, 0, 0, 0);
        check("t1_bubble", 65'(if_id_o.valid), 65'd0);

        // Grant delayed three cycles: request held stable
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            check("t2_hold_addr", 65'({imem_req_o, imem_addr_o}), {32'd0, 1'b1, 32'h8});
        end
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("t2_gnt_addr", 65'(imem_addr_o), 65'h8);
        push(32'h8);
        cyc(0, 1, word_at(32'h8), 0, 0, 0, 0);

        // Stall across the response of 0xC
        cyc(1, 0, 0, 1, 0, 0, 0);
        check("t3_addr_c", 65'(imem_addr_o), 65'hC);
        push(32'hC);
        cyc(0, 1, word_at(32'hC), 1, 0, 0, 0);
        check("t3_hold0", 65'(if_id_o), {32'h8, word_at(32'h8), 1'b1});
        cyc(0, 0, 0, 1, 0, 0, 0);
        check("t3_hold1", 65'(if_id_o), {32'h8, word_at(32'h8), 1'b1});
        cyc(0, 0, 0, 1, 0, 0, 0);
        check("t3_hold2", 65'(if_id_o), {32'h8, word_at(32'h8), 1'b1});
        check("t3_no_req", 65'(imem_req_o), 65'd0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("t3_hold3", 65'(if_id_o), {32'h8, word_at(32'h8), 1'b1});
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("t3_next_addr", 65'({imem_req_o, imem_addr_o}), {32'd0, 1'b1, 32'h10});
        push(32'h10);
        cyc(0, 1, word_at(32'h10), 0, 0, 0, 0);

        // Redirect while waiting: stale 0x14 response dropped
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("t4_addr14", 65'(imem_addr_o), 65'h14);
        cyc(0, 0, 0, 0, 0, 1, 32'h100);
        check("t4_redir_req", 65'(imem_req_o), 65'd0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("t4_wait_req", 65'(imem_req_o), 65'd0);
        cyc(0, 1, word_at(32'h14), 0, 0, 0, 0);
        check("t4_stale_req", 65'(imem_req_o), 65'd0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("t4_stale_drop", 65'(if_id_o.valid), 65'd0);
        check("t4_addr100", 65'({imem_req_o, imem_addr_o}), {32'd0, 1'b1, 32'h100});
        push(32'h100);
        cyc(0, 1, word_at(32'h100), 0, 0, 0, 0);

        // Redirect + rvalid + flush together
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("t5_addr104", 65'(imem_addr_o), 65'h104);
        cyc(0, 1, word_at(32'h104), 0, 1, 1, 32'h200);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("t5_flushed", 65'(if_id_o.valid), 65'd0);
        check("t5_addr200", 65'({imem_req_o, imem_addr_o}), {32'd0, 1'b1, 32'h200});
        push(32'h200);
        cyc(0, 1, word_at(32'h200), 0, 0, 0, 0);

        // Redirect to the top of memory: PC wraps to 0
        cyc(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        check("t6_redir_req", 65'(imem_req_o), 65'd0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("t6_addr_top", 65'(imem_addr_o), 65'hFFFF_FFFC);
        push(32'hFFFF_FFFC);
        cyc(0, 1, word_at(32'hFFFF_FFFC), 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("t6_wrap_addr", 65'({imem_req_o, imem_addr_o}), {32'd0, 1'b1, 32'h0});
        push(32'h0);
        cyc(0, 1, word_at(32'h0), 0, 0, 0, 0);

        // Misaligned redirect target is aligned down
        cyc(0, 0, 0, 0, 0, 1, 32'h203);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("t6_align_addr", 65'(imem_addr_o), 65'h200);
        push(32'h200);
        cyc(0, 1, word_at(32'h200), 0, 0, 0, 0);

        // rvalid + stall + redirect: redirect wins, word dropped
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("t7_addr204", 65'(imem_addr_o), 65'h204);
        cyc(0, 1, word_at(32'h204), 1, 0, 1, 32'h300);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("t7_addr300", 65'({imem_req_o, imem_addr_o}), {32'd0, 1'b1, 32'h300});
        check("t7_no_deliver", 65'(if_id_o.valid), 65'd0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("t7_still_empty", 65'(if_id_o.valid), 65'd0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("all_delivered", 65'(exp_q.size()), 65'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
